sram_like_bridge: RTL and testbench
===================================

Name: sram_like_bridge

Overview:
Parametrised successor to the separate inst/data SRAM-to-SRAM-like converters: one block that turns a pipeline-side SRAM access into an SRAM-like req/addr_ok/data_ok transaction. It holds the pipeline with a stall flag until the data returns, and holds the returned data until the global stall releases. It adds byte-enable-to-size/offset derivation for 32/64-bit buses, a read-only mode for the fetch port, and flush-safe discard of in-flight responses. It sits between the pipeline (dataPath) and the cache/AXI bridge, instantiated once per port.

Parameters:
DATA_W, 32, data bus width; legal values 32 or 64; BE_W = DATA_W/8.
ADDR_W, 32, address width.
READ_ONLY, 0, 1 = fetch port; writes never issued, wen ignored.
FLUSH_EN, 1, 1 = honour flush by discarding the outstanding response; 0 = flush input ignored.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
longest_stall  in  1  global pipeline stall; returned data is held while high
flush  in  1  exception flush; the current access result is discarded
stall  out  1  port stall to hazard unit
sram_en  in  1  access request from pipeline
sram_wen  in  BE_W  byte write enables; all zero = read
sram_addr  in  ADDR_W  byte address
sram_wdata  in  DATA_W  write data
sram_rdata  out  DATA_W  read data to pipeline
req  out  1  SRAM-like request
wr  out  1  1 = write
size  out  2  0=byte 1=half 2=word 3=dword (DATA_W=64 only)
addr  out  ADDR_W  request address
wdata  out  DATA_W  write data
addr_ok  in  1  address accepted
data_ok  in  1  data returned / write acknowledged
rdata  in  DATA_W  returned data

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous, active-high.
- Reset values: state=IDLE, discard=0, saved data=0. All outputs read 0 after reset: req, wr, size, addr, wdata, sram_rdata, stall (stall is 0 because sram_en is 0).
- FSM states and transitions:
  - IDLE: if sram_en and not (flush & FLUSH_EN), go to REQ.
  - REQ: req=1. On addr_ok & data_ok, go to DONE. On addr_ok only, go to WAIT.
  - WAIT: on data_ok, go to DONE.
  - DONE: if ~longest_stall, go to IDLE.
- Request fields: req/wr/size/addr/wdata are driven combinationally from sram_* while in REQ only; all zero in other states. The pipeline holds sram_* stable under stall.
- wr = |sram_wen & ~READ_ONLY.
- size/addr for reads: size = log2(BE_W), addr aligned to DATA_W.
- size/addr for writes, decoded from sram_wen:
  - one-hot byte -> size 0, addr = {addr[hi:lg], byte index}.
  - contiguous aligned pair -> size 1.
  - aligned quad -> size 2.
  - all ones -> full width.
  - any other pattern -> full-width size with aligned addr; the lane mask is resolved downstream.
- Data return: rdata is registered on the data_ok cycle. sram_rdata = saved data while in DONE, else 0. Byte extraction stays in mem_control.
- stall = sram_en & ~(state==DONE & ~discard). IDLE with sram_en therefore stalls the same cycle. Minimum latency: 1 cycle in REQ with addr_ok&data_ok, then DONE the next cycle, where stall=0.
- Flush (FLUSH_EN=1):
  - flush in REQ/WAIT sets discard. req keeps being held until addr_ok, because the protocol forbids withdrawal.
  - On data_ok with discard set: go to IDLE (not DONE), clear discard, drop the data.
  - flush in DONE: go to IDLE, and the held data is dropped.
  - flush in IDLE blocks issue that cycle.
- longest_stall high in DONE: stay in DONE, hold sram_rdata, stall=0.
- Simultaneous cases:
  - data_ok in the same cycle as flush: discard applies.
  - addr_ok & data_ok in REQ with flush: go to IDLE.
- Reset mid-transaction returns to IDLE immediately. Stale data_ok arrivals are the interconnect's responsibility, since it is reset by the same rst.
- READ_ONLY=1: wr=0 always and size is full width.

Decomposition:
- Shared package mycpu_bus_pkg holds:
  - state enum localparams IDLE/REQ/WAIT/DONE (2 bits);
  - SIZE_B/H/W/D constants;
  - a be_to_size function.
- One natural sub-module: sram_like_be_decode, combinational, mapping sram_wen + addr to size/addr.
- The FSM stays in the top module.

Test Plan:
- Read, zero wait: sram_en=1, wen=0, addr=0xBFC00004; addr_ok&data_ok in cycle 1 with rdata=0x24010001 -> req=1 and size=2 for one cycle; stall falls next cycle; sram_rdata=0x24010001.
- Byte store with waits: wen=4'b0100, addr=0x80001002; addr_ok at cycle 3, data_ok at cycle 6 -> req 1 for cycles 1-3; wr=1, size=0, addr=0x80001002; stall high until cycle 7.
- Held data: data_ok with rdata=0xDEADBEEF while longest_stall=1 for 4 cycles -> sram_rdata stays 0xDEADBEEF and stall=0 throughout; IDLE after longest_stall drops.
- Flush in WAIT: addr_ok accepted, flush pulses, data_ok 2 cycles later -> data discarded, sram_rdata=0; a new fetch at 0xBFC00380 issues afterwards and its data is returned.
- DATA_W=64 dword store: wen=8'hFF -> size=3, aligned addr. Half store wen=8'h30 -> size=1, addr offset 4.
- Async reset asserted in WAIT (between clock edges) -> req=0, stall=0 (sram_en low), state IDLE immediately.

Source files
------------

// File: rtl/mycpu_bus_pkg.sv
// mycpu_bus_pkg -- shared state encoding, size codes and byte-enable decoding for the SRAM-like bridge.
// Revision 1.0
`default_nettype none

package mycpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } bus_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef struct packed {
    logic [1:0] size;
    logic [2:0] off;
  } be_dec_t;

  // Naturally aligned 1/2/4-byte masks map to a narrow access; anything else is a full-width access.
  function automatic be_dec_t be_to_size(input logic [7:0] be, input int be_w);
    be_dec_t d;
    d.size = (be_w == 8) ? SIZE_D : SIZE_W;
    d.off  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i < be_w && be == 8'(8'h01 << i)) begin
        d.size = SIZE_B;
        d.off  = 3'(i);
      end
    end
    for (int i = 0; i < 8; i += 2) begin
      if (i < be_w && be == 8'(8'h03 << i)) begin
        d.size = SIZE_H;
        d.off  = 3'(i);
      end
    end
    for (int i = 0; i < 8; i += 4) begin
      if (i < be_w && be == 8'(8'h0F << i) && be_w == 8) begin
        d.size = SIZE_W;
        d.off  = 3'(i);
      end
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sram_like_be_decode.sv
// sram_like_be_decode -- combinational write-enable to wr/size/addr mapping.
// Revision 1.0
`default_nettype none

module sram_like_be_decode
  import mycpu_bus_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int READ_ONLY = 0
) (
  input  logic [DATA_W/8-1:0] wen,
  input  logic [ADDR_W-1:0]   addr_in,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr_out
);

  localparam int BE_W = DATA_W / 8;
  localparam int LG   = $clog2(BE_W);
  localparam logic [1:0] SIZE_FULL = 2'(LG);

  logic [7:0] be8;
  be_dec_t    dec;
  logic       unused_bits;

  always_comb begin
    be8 = 8'd0;
    be8[BE_W-1:0] = wen;
  end

  assign dec = be_to_size(be8, BE_W);
  assign wr  = (READ_ONLY == 0) ? (|wen) : 1'b0;

  always_comb begin
    size     = SIZE_FULL;
    addr_out = {addr_in[ADDR_W-1:LG], {LG{1'b0}}};
    if (wr) begin
      size     = dec.size;
      addr_out = {addr_in[ADDR_W-1:LG], dec.off[LG-1:0]};
    end
  end

  assign unused_bits = ^{addr_in[LG-1:0], dec.off};

endmodule

`default_nettype wire

// File: rtl/sram_like_bridge.sv
// sram_like_bridge -- pipeline SRAM port to SRAM-like req/addr_ok/data_ok bridge with stall, hold and flush discard.
// Revision 1.0
`default_nettype none

module sram_like_bridge
  import mycpu_bus_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int READ_ONLY = 0,
  parameter int FLUSH_EN  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                longest_stall,
  input  logic                flush,
  output logic                stall,
  input  logic                sram_en,
  input  logic [DATA_W/8-1:0] sram_wen,
  input  logic [ADDR_W-1:0]   sram_addr,
  input  logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W-1:0]   sram_rdata,
  output logic                req,
  output logic                wr,
  output logic [1:0]          size,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  input  logic                addr_ok,
  input  logic                data_ok,
  input  logic [DATA_W-1:0]   rdata
);

  bus_state_t          state;
  logic                discard;
  logic [DATA_W-1:0]   saved;

  logic                flush_eff;
  logic                resp;
  logic                drop;
  logic                in_req;
  logic                dec_wr;
  logic [1:0]          dec_size;
  logic [ADDR_W-1:0]   dec_addr;

  sram_like_be_decode #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .READ_ONLY (READ_ONLY)
  ) u_decode (
    .wen      (sram_wen),
    .addr_in  (sram_addr),
    .wr       (dec_wr),
    .size     (dec_size),
    .addr_out (dec_addr)
  );

  assign flush_eff = (FLUSH_EN != 0) ? flush : 1'b0;
  assign resp      = (state == REQ && addr_ok && data_ok) || (state == WAIT && data_ok);
  // A flush arriving with the response must discard it just like an earlier one.
  assign drop      = discard | flush_eff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
      saved   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sram_en && !flush_eff) state <= REQ;
        end
        REQ, WAIT: begin
          if (resp) begin
            discard <= 1'b0;
            if (drop) begin
              state <= IDLE;
            end else begin
              state <= DONE;
              saved <= rdata;
            end
          end else begin
            if (flush_eff) discard <= 1'b1;
            if (state == REQ && addr_ok) state <= WAIT;
          end
        end
        DONE: begin
          if (flush_eff) begin
            state <= IDLE;
            saved <= '0;
          end else if (!longest_stall) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_req     = (state == REQ);
  assign req        = in_req;
  assign wr         = in_req & dec_wr;
  assign size       = in_req ? dec_size : 2'd0;
  assign addr       = in_req ? dec_addr : '0;
  assign wdata      = in_req ? sram_wdata : '0;
  assign sram_rdata = (state == DONE) ? saved : '0;
  assign stall      = sram_en & ~((state == DONE) & ~discard);

endmodule

`default_nettype wire

// File: tb/tb_sram_like_bridge.sv
// tb_sram_like_bridge -- directed plus randomized transactions checked against a transaction-level model.
// Revision 1.0
`default_nettype none

module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        longest_stall = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic        sram_en = 1'b0;
  logic [3:0]  sram_wen = 4'd0;
  logic [31:0] sram_addr = 32'd0;
  logic [31:0] sram_wdata = 32'd0;
  logic [31:0] sram_rdata;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = 32'd0;

  logic        en64 = 1'b0;
  logic [7:0]  wen64 = 8'd0;
  logic [31:0] addr64 = 32'd0;
  logic [63:0] wdata64 = 64'd0;
  logic        stall64;
  logic [63:0] rdata_o64;
  logic        req64;
  logic        wr64;
  logic [1:0]  size64;
  logic [31:0] addr_o64;
  logic [63:0] wdata_o64;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_like_bridge #(.DATA_W(32), .ADDR_W(32), .READ_ONLY(0), .FLUSH_EN(1)) dut (
    .clk(clk), .rst(rst), .longest_stall(longest_stall), .flush(flush), .stall(stall),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
  );

  sram_like_bridge #(.DATA_W(64), .ADDR_W(32), .READ_ONLY(0), .FLUSH_EN(1)) dut64 (
    .clk(clk), .rst(rst), .longest_stall(1'b0), .flush(1'b0), .stall(stall64),
    .sram_en(en64), .sram_wen(wen64), .sram_addr(addr64), .sram_wdata(wdata64),
    .sram_rdata(rdata_o64), .req(req64), .wr(wr64), .size(size64), .addr(addr_o64), .wdata(wdata_o64),
    .addr_ok(1'b0), .data_ok(1'b0), .rdata(64'd0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference decode: popcount and lowest set lane decide whether the mask is a naturally aligned 1/2/4-byte run.
  function automatic void ref_dec(input logic [7:0] be, input int bew, input logic [31:0] a,
                                  output logic ewr, output logic [1:0] esz, output logic [31:0] ea);
    int n = 0;
    int lsb = -1;
    int pat;
    logic [31:0] aligned;
    aligned = a & ~(32'(bew) - 32'd1);
    for (int i = 0; i < bew; i++) begin
      if (be[i]) begin
        n++;
        if (lsb < 0) lsb = i;
      end
    end
    ewr = (n != 0);
    esz = (bew == 8) ? 2'd3 : 2'd2;
    ea  = aligned;
    if (ewr) begin
      pat = ((1 << n) - 1) << lsb;
      if (int'(be) == pat && (n == 1 || n == 2 || n == 4) && (lsb % n) == 0) begin
        esz = (n == 1) ? 2'd0 : (n == 2) ? 2'd1 : 2'd2;
        ea  = aligned | 32'(lsb);
      end
    end
  endfunction

  // fl: 0 none, 1 flush on first REQ cycle, 2 flush on first WAIT cycle, 3 flush on first DONE cycle.
  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int a_dly, input int d_dly,
                        input int ls_n, input int fl);
    logic ewr;
    logic [1:0] esz;
    logic [31:0] ea;
    logic en;
    ref_dec({4'd0, w}, 4, a, ewr, esz, ea);
    en = 1'b1;
    sram_en = 1'b1; sram_wen = w; sram_addr = a; sram_wdata = wd;
    addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0; longest_stall = 1'b0; rdata = $urandom;
    #3;
    chk("idle_stall", {63'd0, stall}, 64'd1);
    chk("idle_req", {63'd0, req}, 64'd0);
    tick();
    for (int k = 0; k <= a_dly; k++) begin
      sram_en = en;
      addr_ok = (k == a_dly);
      data_ok = (k == a_dly) && (d_dly == 0);
      flush   = (fl == 1) && (k == 0);
      rdata   = data_ok ? rd : $urandom;
      #3;
      chk("req", {63'd0, req}, 64'd1);
      chk("wr", {63'd0, wr}, {63'd0, ewr});
      chk("size", {62'd0, size}, {62'd0, esz});
      chk("addr", {32'd0, addr}, {32'd0, ea});
      chk("wdata", {32'd0, wdata}, {32'd0, wd});
      chk("req_stall", {63'd0, stall}, {63'd0, en});
      if (flush) en = 1'b0;
      tick();
    end
    for (int j = 1; j <= d_dly; j++) begin
      sram_en = en;
      addr_ok = 1'b0;
      data_ok = (j == d_dly);
      flush   = (fl == 2) && (j == 1);
      rdata   = data_ok ? rd : $urandom;
      #3;
      chk("wait_req", {63'd0, req}, 64'd0);
      chk("wait_stall", {63'd0, stall}, {63'd0, en});
      if (flush) en = 1'b0;
      tick();
    end
    addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0; rdata = $urandom; sram_en = en;
    if (fl == 0 || fl == 3) begin
      for (int c = 0; c <= ls_n; c++) begin
        longest_stall = (fl == 3) ? 1'b1 : (c < ls_n);
        flush = (fl == 3);
        #3;
        chk("done_rdata", {32'd0, sram_rdata}, {32'd0, rd});
        chk("done_stall", {63'd0, stall}, 64'd0);
        chk("done_req", {63'd0, req}, 64'd0);
        tick();
        if (fl == 3) break;
      end
    end
    sram_en = 1'b0; flush = 1'b0; longest_stall = 1'b0;
    #3;
    chk("after_rdata", {32'd0, sram_rdata}, 64'd0);
    chk("after_stall", {63'd0, stall}, 64'd0);
    chk("after_req", {63'd0, req}, 64'd0);
    tick();
  endtask

  initial begin
    logic ewr;
    logic [1:0] esz;
    logic [31:0] ea;
    logic [7:0] pats [6];
    pats[0] = 8'h01; pats[1] = 8'h0C; pats[2] = 8'hF0; pats[3] = 8'hFF; pats[4] = 8'h30; pats[5] = 8'h06;

    // Reset state
    #3;
    chk("rst_req", {63'd0, req}, 64'd0);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_rdata", {32'd0, sram_rdata}, 64'd0);
    chk("rst_bus", {29'd0, wr, size, addr}, 64'd0);
    chk("rst_wdata", {32'd0, wdata}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Directed transactions
    access(4'b0000, 32'hBFC00004, 32'h0, 32'h24010001, 0, 0, 0, 0);
    access(4'b0100, 32'h80001002, 32'h00AB0000, 32'h12345678, 2, 3, 0, 0);
    access(4'b0000, 32'h80002000, 32'h0, 32'hDEADBEEF, 0, 1, 4, 0);
    access(4'b0000, 32'hBFC00100, 32'h0, 32'hCAFEF00D, 1, 2, 0, 2);
    access(4'b0000, 32'hBFC00380, 32'h0, 32'h3C1ABFC0, 0, 0, 0, 0);
    access(4'b0000, 32'hBFC00390, 32'h0, 32'h11112222, 0, 0, 0, 1);
    access(4'b1100, 32'h80000012, 32'h55660000, 32'h0BADF00D, 0, 1, 0, 3);

    // Flush in IDLE blocks issue for that cycle
    sram_en = 1'b1; sram_wen = 4'd0; sram_addr = 32'h1000; flush = 1'b1;
    #3;
    chk("idle_flush_req", {63'd0, req}, 64'd0);
    chk("idle_flush_stall", {63'd0, stall}, 64'd1);
    tick();
    flush = 1'b0;
    access(4'b0000, 32'h00001000, 32'h0, 32'h77778888, 0, 0, 1, 0);

    // Randomized transactions
    for (int t = 0; t < 40; t++) begin
      logic [3:0] w;
      int ad, dd, fl;
      w  = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      ad = $urandom_range(0, 3);
      dd = $urandom_range(0, 3);
      fl = $urandom_range(0, 6);
      if (fl > 3 || (fl == 2 && dd == 0)) fl = 0;
      access(w, $urandom, $urandom, $urandom, ad, dd, $urandom_range(0, 3), fl);
    end

    // 64-bit instance parked in REQ for decode checks
    en64 = 1'b1;
    tick();
    for (int t = 0; t < 24; t++) begin
      wen64  = (t < 6) ? pats[t] : 8'($urandom);
      addr64 = (t < 6) ? 32'h80000105 : $urandom;
      wdata64 = {$urandom, $urandom};
      ref_dec(wen64, 8, addr64, ewr, esz, ea);
      #1;
      chk("d64_req", {63'd0, req64}, 64'd1);
      chk("d64_wr", {63'd0, wr64}, {63'd0, ewr});
      chk("d64_size", {62'd0, size64}, {62'd0, esz});
      chk("d64_addr", {32'd0, addr_o64}, {32'd0, ea});
      chk("d64_wdata", wdata_o64, wdata64);
    end

    // Asynchronous reset while waiting for data
    sram_en = 1'b1; sram_wen = 4'd0; sram_addr = 32'h2000;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    #1;
    chk("wait_before_rst", {63'd0, stall}, 64'd1);
    #1;
    rst = 1'b1; sram_en = 1'b0;
    #1;
    chk("arst_req", {63'd0, req}, 64'd0);
    chk("arst_stall", {63'd0, stall}, 64'd0);
    chk("arst_req64", {63'd0, req64}, 64'd0);
    sram_en = 1'b1;
    #1;
    chk("arst_idle_stall", {63'd0, stall}, 64'd1);
    sram_en = 1'b0;
    tick();
    rst = 1'b0; en64 = 1'b0;
    tick();
    access(4'b0001, 32'h00003003, 32'h000000EE, 32'hA5A5A5A5, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
